axi_pmu_lat: RTL and testbench

AXI_PMU_LAT -- requirements
Module: axi_pmu_lat

---
 rtl/axi_pmu_lat.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_pmu_lat.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pmu_lat.sv
// rtl/axi_pmu_lat.sv - passive AXI performance monitor: handshake/stall counters and read/write latency statistics
//
// Ports:
//   aclk          clock, all state changes on the rising edge
//   aresetn       asynchronous active-low reset
//   mon_axi_miso  observed slave-to-master channel signals
//   mon_axi_mosi  observed master-to-slave channel signals
//   en_i          statistic counting enable
//   clr_i         synchronous clear of the statistic counters
//   addr_i        counter select
//   data_o        selected counter value (combinational from addr_i)

package axi_pmu_lat_pkg;
    localparam int PKG_ID_W_WIDTH     = 4;
    localparam int PKG_ID_R_WIDTH     = 4;
    localparam int PKG_ADDR_WIDTH     = 16;
    localparam int PKG_AXI_DATA_WIDTH = 32;

    typedef struct packed {
        logic [PKG_ID_W_WIDTH-1:0]       aw_id;
        logic [PKG_ADDR_WIDTH-1:0]       aw_addr;
        logic                            aw_valid;
        logic [PKG_AXI_DATA_WIDTH-1:0]   w_data;
        logic [PKG_AXI_DATA_WIDTH/8-1:0] w_strb;
        logic                            w_last;
        logic                            w_valid;
        logic                            b_ready;
        logic [PKG_ID_R_WIDTH-1:0]       ar_id;
        logic [PKG_ADDR_WIDTH-1:0]       ar_addr;
        logic                            ar_valid;
        logic                            r_ready;
    } axi_mosi_t;

    typedef struct packed {
        logic                            aw_ready;
        logic                            w_ready;
        logic [PKG_ID_W_WIDTH-1:0]       b_id;
        logic [1:0]                      b_resp;
        logic                            b_valid;
        logic                            ar_ready;
        logic [PKG_ID_R_WIDTH-1:0]       r_id;
        logic [PKG_AXI_DATA_WIDTH-1:0]   r_data;
        logic [1:0]                      r_resp;
        logic                            r_last;
        logic                            r_valid;
    } axi_miso_t;
endpackage

module axi_pmu_lat #(
    parameter int ID_W_WIDTH     = axi_pmu_lat_pkg::PKG_ID_W_WIDTH,
    parameter int ID_R_WIDTH     = axi_pmu_lat_pkg::PKG_ID_R_WIDTH,
    parameter int MAX_ID_WIDTH   = 4,
    parameter int ADDR_WIDTH     = axi_pmu_lat_pkg::PKG_ADDR_WIDTH,
    parameter int AXI_DATA_WIDTH = axi_pmu_lat_pkg::PKG_AXI_DATA_WIDTH,
    parameter int CNT_WIDTH      = 32,
    parameter int LAT_DEPTH      = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  axi_pmu_lat_pkg::axi_miso_t mon_axi_miso,
    input  axi_pmu_lat_pkg::axi_mosi_t mon_axi_mosi,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic [4:0]                 addr_i,
    output logic [CNT_WIDTH-1:0]       data_o
);
    localparam int PTR_W = $clog2(LAT_DEPTH);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(LAT_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    // Addresses holding plain saturating event counters
    localparam logic [31:0] STAT_MASK = 32'h0667_FCFD;

    logic ar_hs, r_hs, rl_hs, aw_hs, w_hs, wl_hs, b_hs;
    logic [CNT_WIDTH-1:0] rd_out, wr_out, wr_resp, ts;
    logic [1:0] push_ev, pop_ev, trk_zero, sample_ev, drop_ev, susp;
    logic [CNT_WIDTH-1:0] lat_sum [2];
    logic [CNT_WIDTH-1:0] lat_max [2];
    logic [31:0] stat_inc;
    logic [CNT_WIDTH-1:0] aux [32];
    logic [CNT_WIDTH-1:0] map [32];

    assign ar_hs = mon_axi_mosi.ar_valid & mon_axi_miso.ar_ready;
    assign r_hs  = mon_axi_miso.r_valid & mon_axi_mosi.r_ready;
    assign rl_hs = r_hs & mon_axi_miso.r_last;
    assign aw_hs = mon_axi_mosi.aw_valid & mon_axi_miso.aw_ready;
    assign w_hs  = mon_axi_mosi.w_valid & mon_axi_miso.w_ready;
    assign wl_hs = w_hs & mon_axi_mosi.w_last;
    assign b_hs  = mon_axi_miso.b_valid & mon_axi_mosi.b_ready;

    // Outstanding-transaction trackers; simultaneous inc/dec cancel, decrement at zero is ignored
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_out  <= '0;
            wr_out  <= '0;
            wr_resp <= '0;
            ts      <= '0;
        end else begin
            ts <= ts + CNT_ONE;
            if (ar_hs && !rl_hs)
                rd_out <= rd_out + CNT_ONE;
            else if (rl_hs && !ar_hs && rd_out != '0)
                rd_out <= rd_out - CNT_ONE;
            if (aw_hs && !b_hs)
                wr_out <= wr_out + CNT_ONE;
            else if (b_hs && !aw_hs && wr_out != '0)
                wr_out <= wr_out - CNT_ONE;
            if (wl_hs && !b_hs)
                wr_resp <= wr_resp + CNT_ONE;
            else if (b_hs && !wl_hs && wr_resp != '0)
                wr_resp <= wr_resp - CNT_ONE;
        end
    end

    // Direction 0 = read (AR push, RLAST pop), direction 1 = write (AW push, B pop)
    assign push_ev  = {aw_hs, ar_hs};
    assign pop_ev   = {b_hs, rl_hs};
    assign trk_zero = {wr_out == '0, rd_out == '0};

    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [CNT_WIDTH-1:0] mem [LAT_DEPTH];
        logic [PTR_W:0]       wp, rp, occ;
        logic                 susp_q, flush, full, empty, do_push, do_pop, sample;
        logic [CNT_WIDTH-1:0] lat, sum_q, max_q;
        logic [CNT_WIDTH:0]   sum_ext;

        assign occ     = wp - rp;
        // Once suspended, stored timestamps no longer line up with completions;
        // they are discarded when the direction drains completely.
        assign flush   = susp_q & trk_zero[d];
        assign full    = !flush && (occ == DEPTH_P);
        assign empty   = (occ == '0);
        assign do_pop  = pop_ev[d] & !empty & !flush;
        assign do_push = push_ev[d] & (!full | do_pop);
        assign sample  = do_pop & !susp_q;
        assign lat     = ts - mem[rp[PTR_W-1:0]];
        assign sum_ext = {1'b0, sum_q} + {1'b0, lat};

        always_ff @(posedge aclk) begin
            if (do_push)
                mem[wp[PTR_W-1:0]] <= ts;
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                wp     <= '0;
                rp     <= '0;
                susp_q <= 1'b0;
            end else begin
                if (do_push)
                    wp <= wp + PTR_ONE;
                if (flush) begin
                    rp     <= wp;
                    susp_q <= 1'b0;
                end else begin
                    if (do_pop)
                        rp <= rp + PTR_ONE;
                    if (drop_ev[d])
                        susp_q <= 1'b1;
                end
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                sum_q <= '0;
                max_q <= '0;
            end else if (clr_i) begin
                sum_q <= '0;
                max_q <= '0;
            end else if (en_i && sample) begin
                sum_q <= sum_ext[CNT_WIDTH] ? '1 : sum_ext[CNT_WIDTH-1:0];
                if (lat > max_q)
                    max_q <= lat;
            end
        end

        assign drop_ev[d]   = push_ev[d] & full & !do_pop;
        assign sample_ev[d] = sample;
        assign susp[d]      = susp_q;
        assign lat_sum[d]   = sum_q;
        assign lat_max[d]   = max_q;
    end

    always_comb begin
        stat_inc     = '0;
        stat_inc[0]  = !mon_axi_mosi.ar_valid && rd_out == '0;
        stat_inc[2]  = mon_axi_mosi.ar_valid && !mon_axi_miso.ar_ready;
        stat_inc[3]  = ar_hs;
        stat_inc[4]  = rd_out != '0 && !mon_axi_miso.r_valid;
        stat_inc[5]  = mon_axi_miso.r_valid && !mon_axi_mosi.r_ready;
        stat_inc[6]  = r_hs;
        stat_inc[7]  = !mon_axi_mosi.aw_valid && wr_out == '0;
        stat_inc[10] = mon_axi_mosi.aw_valid && !mon_axi_miso.aw_ready;
        stat_inc[11] = aw_hs;
        // Write data is still owed only while some accepted AW has no WLAST yet
        stat_inc[12] = wr_out != '0 && wr_out != wr_resp && !mon_axi_mosi.w_valid;
        stat_inc[13] = mon_axi_mosi.w_valid && !mon_axi_miso.w_ready;
        stat_inc[14] = w_hs;
        stat_inc[15] = wr_resp != '0 && !mon_axi_miso.b_valid;
        stat_inc[16] = mon_axi_miso.b_valid && !mon_axi_mosi.b_ready;
        stat_inc[17] = b_hs;
        stat_inc[18] = 1'b1;
        stat_inc[21] = sample_ev[0];
        stat_inc[22] = drop_ev[0];
        stat_inc[25] = sample_ev[1];
        stat_inc[26] = drop_ev[1];
    end

    always_comb begin
        for (int i = 0; i < 32; i++)
            aux[i] = '0;
        aux[1]  = rd_out;
        aux[8]  = wr_out;
        aux[9]  = wr_resp;
        aux[19] = lat_sum[0];
        aux[20] = lat_max[0];
        aux[23] = lat_sum[1];
        aux[24] = lat_max[1];
        aux[27] = CNT_WIDTH'({susp[1], susp[0], en_i});
    end

    for (genvar a = 0; a < 32; a++) begin : g_map
        if (STAT_MASK[a]) begin : g_cnt
            logic [CNT_WIDTH-1:0] q;
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn)
                    q <= '0;
                else if (clr_i)
                    q <= '0;
                else if (en_i && stat_inc[a] && q != '1)
                    q <= q + CNT_ONE;
            end
            assign map[a] = q;
        end else begin : g_aux
            assign map[a] = aux[a];
        end
    end

    assign data_o = map[addr_i];

    logic unused_ok;
    assign unused_ok = ^{mon_axi_mosi, mon_axi_miso, stat_inc,
                         ID_W_WIDTH[0], ID_R_WIDTH[0], MAX_ID_WIDTH[0],
                         ADDR_WIDTH[0], AXI_DATA_WIDTH[0]};
endmodule

// File: tb/tb_axi_pmu_lat.sv
// tb/tb_axi_pmu_lat.sv - scoreboard testbench for axi_pmu_lat
module tb_axi_pmu_lat;
    import axi_pmu_lat_pkg::*;

    localparam int W = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          en_i;
    logic          clr_i;
    logic [4:0]    addr_i;
    logic [W-1:0]  data_o;
    axi_mosi_t     mosi;
    axi_miso_t     miso;
    logic          rd_vld;

    typedef struct {
        logic [4:0]   addr;
        logic [W-1:0] val;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    axi_pmu_lat #(.CNT_WIDTH(W), .LAT_DEPTH(8)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .mon_axi_miso (miso),
        .mon_axi_mosi (mosi),
        .en_i         (en_i),
        .clr_i        (clr_i),
        .addr_i       (addr_i),
        .data_o       (data_o)
    );

    always #5 aclk = ~aclk;

    // Monitor: compares every presented read against the oldest expectation
    always @(negedge aclk) begin
        if (rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expectation: got %h required a queued value", data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_o !== e.val) begin
                    errors++;
                    $display("FAIL %0s (addr %0d): got %h required %h", e.name, e.addr, data_o, e.val);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        mosi = '0;
        miso = '0;
    endtask

    task automatic check_now(input logic [4:0] a, input logic [W-1:0] v, input string nm);
        exp_t e;
        e.addr = a;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
        addr_i = a;
        rd_vld = 1'b1;
        tick();
        rd_vld = 1'b0;
    endtask

    task automatic chk(input logic [4:0] a, input logic [W-1:0] v, input string nm);
        en_i = 1'b0;
        check_now(a, v, nm);
    endtask

    task automatic do_ar(); mosi.ar_valid = 1'b1; miso.ar_ready = 1'b1; endtask
    task automatic do_rl(); miso.r_valid = 1'b1; mosi.r_ready = 1'b1; miso.r_last = 1'b1; endtask

    task automatic clear_stats();
        en_i  = 1'b1;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        en_i    = 1'b1;
        clr_i   = 1'b0;
        addr_i  = '0;
        rd_vld  = 1'b0;
        idle();
        repeat (2) tick();

        // Reset state
        check_now(5'd18, 16'h0000, "reset_cycles");
        check_now(5'd27, 16'h0001, "reset_status_en");
        check_now(5'd1,  16'h0000, "reset_rd_out");
        check_now(5'd20, 16'h0000, "reset_rd_lat_max");

        // Single read: AR at ts=10, RL at ts=17
        aresetn = 1'b1;
        repeat (10) tick();
        do_ar(); tick(); idle();
        repeat (6) tick();
        do_rl(); tick(); idle();
        chk(5'd19, 16'd7,  "rd_lat_sum");
        chk(5'd20, 16'd7,  "rd_lat_max");
        chk(5'd21, 16'd1,  "rd_lat_cnt");
        chk(5'd3,  16'd1,  "ar_hs");
        chk(5'd1,  16'd0,  "rd_out_idle");
        chk(5'd4,  16'd6,  "rvalid_stall");
        chk(5'd6,  16'd1,  "r_hs");
        chk(5'd0,  16'd10, "rd_idle");
        chk(5'd7,  16'd18, "wr_idle");
        chk(5'd18, 16'd18, "cycles_rd");

        // Write with backpressure and gaps
        clear_stats();
        mosi.aw_valid = 1'b1;
        repeat (3) tick();
        miso.aw_ready = 1'b1; tick(); idle();
        tick();
        for (int i = 0; i < 4; i++) begin
            mosi.w_valid = 1'b1; miso.w_ready = 1'b1; mosi.w_last = (i == 3);
            tick();
        end
        idle();
        tick();
        miso.b_valid = 1'b1;
        repeat (2) tick();
        mosi.b_ready = 1'b1; tick(); idle();
        chk(5'd10, 16'd3,  "aw_stall");
        chk(5'd11, 16'd1,  "aw_hs");
        chk(5'd14, 16'd4,  "w_hs");
        chk(5'd12, 16'd1,  "wvalid_stall");
        chk(5'd15, 16'd1,  "bvalid_stall");
        chk(5'd16, 16'd2,  "bready_stall");
        chk(5'd17, 16'd1,  "b_hs");
        chk(5'd9,  16'd0,  "wr_resp");
        chk(5'd8,  16'd0,  "wr_out");
        chk(5'd23, 16'd9,  "wr_lat_sum");
        chk(5'd24, 16'd9,  "wr_lat_max");
        chk(5'd25, 16'd1,  "wr_lat_cnt");
        chk(5'd0,  16'd13, "rd_idle_wr");
        chk(5'd18, 16'd13, "cycles_wr");
        chk(5'd19, 16'd0,  "rd_lat_sum_cleared");

        // AR and RL in the same cycle with one read outstanding
        clear_stats();
        do_ar(); tick(); idle();
        repeat (2) tick();
        do_ar(); do_rl(); tick(); idle();
        chk(5'd1, 16'd1, "rd_out_simul");
        en_i = 1'b1;
        do_rl(); tick(); idle();
        chk(5'd21, 16'd2, "simul_lat_cnt");
        chk(5'd19, 16'd5, "simul_lat_sum");
        chk(5'd20, 16'd3, "simul_lat_max");
        chk(5'd1,  16'd0, "simul_rd_out");
        chk(5'd3,  16'd2, "simul_ar_hs");
        chk(5'd6,  16'd2, "simul_r_hs");

        // Freeze: traffic with counting disabled
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_ar(); tick(); idle();
            do_rl(); tick(); idle();
        end
        chk(5'd3,  16'd2, "freeze_ar_hs");
        chk(5'd6,  16'd2, "freeze_r_hs");
        chk(5'd21, 16'd2, "freeze_lat_cnt");
        chk(5'd19, 16'd5, "freeze_lat_sum");
        chk(5'd1,  16'd0, "freeze_rd_out");

        // Overflow of the read timestamp FIFO
        clear_stats();
        repeat (9) begin do_ar(); tick(); end
        idle();
        chk(5'd22, 16'd1, "ovf_rd_drop");
        chk(5'd27, 16'd2, "ovf_status_susp");
        chk(5'd1,  16'd9, "ovf_rd_out");
        en_i = 1'b1;
        repeat (9) begin do_rl(); tick(); end
        idle();
        tick();
        chk(5'd27, 16'd0, "ovf_status_clear");
        chk(5'd21, 16'd0, "ovf_lat_cnt");
        chk(5'd1,  16'd0, "ovf_rd_out_drained");
        chk(5'd6,  16'd9, "ovf_r_hs");
        chk(5'd22, 16'd1, "ovf_rd_drop_hold");
        en_i = 1'b1;
        do_ar(); tick(); idle();
        tick();
        do_rl(); tick(); idle();
        chk(5'd21, 16'd1, "recover_lat_cnt");
        chk(5'd19, 16'd2, "recover_lat_sum");
        chk(5'd30, 16'd0, "unmapped_addr");

        // Reset in the middle of a transaction
        en_i = 1'b1;
        do_ar(); mosi.aw_valid = 1'b1; miso.aw_ready = 1'b1; tick(); idle();
        chk(5'd1, 16'd1, "pre_reset_rd_out");
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk(5'd1,  16'd0, "mid_reset_rd_out");
        chk(5'd8,  16'd0, "mid_reset_wr_out");
        en_i = 1'b1;
        do_rl(); tick(); idle();
        chk(5'd21, 16'd0, "post_reset_no_sample");
        chk(5'd1,  16'd0, "post_reset_no_underflow");
        chk(5'd6,  16'd1, "post_reset_r_hs");

        // Saturation and clear priority
        clear_stats();
        repeat (70000) tick();
        check_now(5'd18, 16'hFFFF, "sat_cycles");
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_now(5'd18, 16'h0000, "clr_cycles");
        check_now(5'd18, 16'h0001, "after_clr_cycles");

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
